mem_arbiter: RTL

Single-port RAM arbiter between the 6502 core and the VGA renderer, sitting directly in front of the 2 KB system RAM (`generic_ram`). It grants each cycle's RAM access to either the renderer or the CPU, drives the CPU `RDY` stall, and routes synchronous read data back to the correct requester. It also implements the easy6502 memory-mapped registers: `$FE` random byte and `$FF` last key.

---
 rtl/easy6502_pkg.sv | 23 ++
 rtl/mem_arbiter_lfsr8.sv | 22 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/easy6502_pkg.sv
// Shared constants and types for the easy6502 system: memory map, LFSR taps,
// and the read-return source tag used by the RAM arbiter.
package easy6502_pkg;

  localparam logic [10:0] ADDR_RANDOM = 11'h0FE;
  localparam logic [10:0] ADDR_KEY    = 11'h0FF;
  localparam logic [10:0] SCREEN_BASE = 11'h200;
  localparam int          SCREEN_SIZE = 1024;
  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;

  typedef enum logic [1:0] {
    SRC_CPU_RAM = 2'd0,
    SRC_CPU_RND = 2'd1,
    SRC_CPU_KEY = 2'd2,
    SRC_VID     = 2'd3
  } src_e;

  // Right-shifting Galois step; taps B8 give a maximal 255-state sequence.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/mem_arbiter_lfsr8.sv
// Free-running 8-bit Galois LFSR backing the $FE random register.
// SEED must be nonzero or the sequence locks at zero.
module lfsr8
  import easy6502_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= SEED;
    else       r_q <= lfsr_next(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the 6502 core and the VGA renderer,
// including the $FE random and $FF key memory-mapped registers.
module mem_arbiter
  import easy6502_pkg::*;
#(
  parameter int         MAX_VID_RUN = 4,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  input  logic        vid_req,
  input  logic [10:0] vid_addr,
  output logic        vid_gnt,
  output logic        vid_valid,
  output logic [7:0]  vid_rdata,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  input  logic        key_strobe,
  input  logic [7:0]  key_code
);

  localparam int RUN_W = $clog2(MAX_VID_RUN + 1);

  logic [RUN_W-1:0] r_vid_run;
  src_e             r_last_src;
  src_e             w_src_next;
  logic [7:0]       r_rnd;
  logic [7:0]       r_key;
  logic [7:0]       r_cpu_hold;
  logic [7:0]       r_vid_rdata;
  logic             r_rst_q;
  logic [7:0]       w_lfsr;
  logic [7:0]       w_cpu_mux;
  logic [10:0]      w_cpu_addr;
  logic             w_vid_gnt;
  logic             w_cpu_gnt;
  logic             w_is_rnd;
  logic             w_is_key;
  logic             w_unused_addr_hi;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Upper address bits are ignored so the 2 KB RAM mirrors through 64 KB.
  assign w_cpu_addr       = cpu_addr[10:0];
  assign w_unused_addr_hi = ^cpu_addr[15:11];

  assign w_vid_gnt = vid_req && (r_vid_run != RUN_W'(MAX_VID_RUN)) && !reset;
  assign w_cpu_gnt = !w_vid_gnt && !reset;
  assign w_is_rnd  = (w_cpu_addr == ADDR_RANDOM);
  assign w_is_key  = (w_cpu_addr == ADDR_KEY);

  assign vid_gnt   = w_vid_gnt;
  assign cpu_rdy   = !w_vid_gnt;
  assign ram_addr  = w_vid_gnt ? vid_addr : w_cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_we    = w_cpu_gnt && cpu_we && !w_is_rnd;

  always_comb begin
    w_src_next = SRC_CPU_RAM;
    if (w_vid_gnt)     w_src_next = SRC_VID;
    else if (w_is_rnd) w_src_next = SRC_CPU_RND;
    else if (w_is_key) w_src_next = SRC_CPU_KEY;
  end

  always_ff @(posedge clk) begin
    if (reset) r_last_src <= SRC_CPU_RAM;
    else       r_last_src <= w_src_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_run   <= '0;
      r_rnd       <= '0;
      r_key       <= '0;
      r_cpu_hold  <= '0;
      r_vid_rdata <= '0;
    end else begin
      if (w_vid_gnt) r_vid_run <= r_vid_run + RUN_W'(1);
      else           r_vid_run <= '0;

      if (w_cpu_gnt && w_is_rnd) r_rnd <= w_lfsr;

      // A keypress wins over a simultaneous CPU store to $FF.
      if (key_strobe)                        r_key <= key_code;
      else if (w_cpu_gnt && cpu_we && w_is_key) r_key <= cpu_wdata;

      if (r_last_src != SRC_VID) r_cpu_hold <= cpu_rdata;
      if (vid_valid)             r_vid_rdata <= ram_rdata;
    end
  end

  // Data returned in the cycle after a reset edge belongs to no real access.
  always_ff @(posedge clk) begin
    r_rst_q <= reset;
  end

  always_comb begin
    w_cpu_mux = ram_rdata;
    case (r_last_src)
      SRC_CPU_RAM: w_cpu_mux = ram_rdata;
      SRC_CPU_RND: w_cpu_mux = r_rnd;
      SRC_CPU_KEY: w_cpu_mux = r_key;
      SRC_VID:     w_cpu_mux = r_cpu_hold;
      default:     w_cpu_mux = ram_rdata;
    endcase
  end

  assign cpu_rdata = r_rst_q ? 8'h00 : w_cpu_mux;
  assign vid_valid = (r_last_src == SRC_VID);
  assign vid_rdata = vid_valid ? ram_rdata : r_vid_rdata;

endmodule
